// File: rtl/screen_pkg.sv
// Shared types and constants for the gameplay/game-over crossfade.
package screen_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    OVER     = 2'd2,
    FADE_IN  = 2'd3
  } screen_state_t;

  localparam int ALPHA_W   = 9;
  localparam int ALPHA_MAX = 256;
  localparam int BLEND_LAT = 3;

endpackage

// File: rtl/pixel_blend.sv
// Three-stage RGB888 alpha blend; syncs/active ride along so they stay aligned with the pixel.
module pixel_blend
  import screen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        game_pixel,
  input  logic [23:0]        over_pixel,
  input  logic [ALPHA_W-1:0] alpha,
  input  logic [2:0]         sideband,
  output logic [23:0]        pixel,
  output logic [2:0]         sideband_dly
);

  localparam logic [ALPHA_W-1:0] MAX_A = ALPHA_W'(ALPHA_MAX);

  logic [23:0]        game_q, over_q;
  logic [ALPHA_W-1:0] alpha_q, inv_alpha;
  logic [16:0]        prod_over [3];
  logic [16:0]        prod_game [3];
  logic [16:0]        sum       [3];
  logic [2:0]         sb        [BLEND_LAT];

  assign inv_alpha = MAX_A - alpha_q;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum[c] = prod_over[c] + prod_game[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      game_q  <= '0;
      over_q  <= '0;
      alpha_q <= '0;
      pixel   <= '0;
      for (int c = 0; c < 3; c++) begin
        prod_over[c] <= '0;
        prod_game[c] <= '0;
      end
      for (int i = 0; i < BLEND_LAT; i++) begin
        sb[i] <= '0;
      end
    end else begin
      game_q  <= game_pixel;
      over_q  <= over_pixel;
      alpha_q <= alpha;
      sb[0]   <= sideband;
      for (int i = 1; i < BLEND_LAT; i++) begin
        sb[i] <= sb[i-1];
      end
      for (int c = 0; c < 3; c++) begin
        prod_over[c] <= 17'(over_q[c*8 +: 8]) * 17'(alpha_q);
        prod_game[c] <= 17'(game_q[c*8 +: 8]) * 17'(inv_alpha);
        // sb[1][0] is the active bit travelling alongside the stage-2 products
        pixel[c*8 +: 8] <= sb[1][0] ? 8'(sum[c] >> 8) : 8'h00;
      end
    end
  end

  assign sideband_dly = sb[BLEND_LAT-1];

endmodule

// File: rtl/screen_transition.sv
// Frame-stepped crossfade between gameplay and game-over streams; alpha moves only on
// new_frame_in so a whole visible region is blended with one factor.
module screen_transition
  import screen_pkg::*;
#(
  parameter int FADE_FRAMES = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_in,
  input  logic        new_frame_in,
  input  logic [23:0] game_pixel_in,
  input  logic [23:0] over_pixel_in,
  input  logic        game_over_in,
  input  logic        restart_in,
  output logic [23:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic [1:0]  state_out,
  output logic        transition_done_out
);

  localparam logic [ALPHA_W-1:0] STEP_A   = ALPHA_W'(ALPHA_MAX / FADE_FRAMES);
  localparam logic [ALPHA_W-1:0] MAX_A    = ALPHA_W'(ALPHA_MAX);
  localparam logic [ALPHA_W:0]   MAX_WIDE = (ALPHA_W+1)'(ALPHA_MAX);

  screen_state_t      state, ev_state, next_state;
  logic [ALPHA_W-1:0] alpha, next_alpha;
  logic [ALPHA_W:0]   alpha_up;
  logic               done, next_done;
  logic [2:0]         sideband_dly;

  always_comb begin
    ev_state   = state;
    next_state = state;
    next_alpha = alpha;
    next_done  = 1'b0;
    alpha_up   = {1'b0, alpha} + {1'b0, STEP_A};

    // game_over_in takes priority over a simultaneous restart_in
    case (state)
      PLAY:     if (game_over_in) ev_state = FADE_OUT;
      FADE_OUT: if (restart_in && !game_over_in) ev_state = FADE_IN;
      OVER:     if (restart_in && !game_over_in) ev_state = FADE_IN;
      FADE_IN:  if (game_over_in) ev_state = FADE_OUT;
      default:  ev_state = PLAY;
    endcase

    next_state = ev_state;
    if (new_frame_in) begin
      case (ev_state)
        FADE_OUT: begin
          if (alpha_up >= MAX_WIDE) begin
            next_alpha = MAX_A;
            next_state = OVER;
            next_done  = 1'b1;
          end else begin
            next_alpha = alpha_up[ALPHA_W-1:0];
          end
        end
        FADE_IN: begin
          if (alpha <= STEP_A) begin
            next_alpha = '0;
            next_state = PLAY;
            next_done  = 1'b1;
          end else begin
            next_alpha = alpha - STEP_A;
          end
        end
        default: next_alpha = alpha;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= PLAY;
      alpha <= '0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      alpha <= next_alpha;
      done  <= next_done;
    end
  end

  pixel_blend u_blend (
    .clk          (clk_in),
    .rst          (rst_in),
    .game_pixel   (game_pixel_in),
    .over_pixel   (over_pixel_in),
    .alpha        (alpha),
    .sideband     ({hsync_in, vsync_in, active_in}),
    .pixel        (pixel_out),
    .sideband_dly (sideband_dly)
  );

  assign hsync_out           = sideband_dly[2];
  assign vsync_out           = sideband_dly[1];
  assign active_out          = sideband_dly[0];
  assign state_out           = state;
  assign transition_done_out = done;

endmodule

// File: tb/tb_screen_transition.sv
// Bench for screen_transition with FADE_FRAMES=4: vector table, reset sequence, random run vs model.
module tb_screen_transition;

  localparam int FF   = 4;
  localparam int STEP = 256 / FF;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, active, nf, go, rs;
  logic [23:0] game_px, over_px;
  logic [23:0] pixel_out;
  logic        hsync_out, vsync_out, active_out, done_out;
  logic [1:0]  state_out;

  int checks   = 0;
  int failures = 0;

  int          m_state, m_alpha, m_done;
  logic [26:0] m_pipe [3];

  typedef struct {
    logic        go, rs, nf, act;
    logic [23:0] game, over, exp_pix;
    int          exp_state;
    logic        exp_done;
  } vec_t;

  vec_t tbl [19];

  screen_transition #(.FADE_FRAMES(FF)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .hsync_in            (hsync),
    .vsync_in            (vsync),
    .active_in           (active),
    .new_frame_in        (nf),
    .game_pixel_in       (game_px),
    .over_pixel_in       (over_px),
    .game_over_in        (go),
    .restart_in          (rs),
    .pixel_out           (pixel_out),
    .hsync_out           (hsync_out),
    .vsync_out           (vsync_out),
    .active_out          (active_out),
    .state_out           (state_out),
    .transition_done_out (done_out)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [23:0] blend(input logic [23:0] g, input logic [23:0] o, input int a);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) begin
      r[c*8 +: 8] = 8'((int'(o[c*8 +: 8]) * a + int'(g[c*8 +: 8]) * (256 - a)) / 256);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic g, input logic r, input logic n, input logic a,
                              input logic [23:0] gp, input logic [23:0] op,
                              input logic [23:0] ep, input int es, input logic ed);
    vec_t v;
    v.go = g; v.rs = r; v.nf = n; v.act = a;
    v.game = gp; v.over = op; v.exp_pix = ep; v.exp_state = es; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: fade rules applied to an integer alpha, plus a 3-deep output queue.
  task automatic model_step();
    if (rst) begin
      m_state = 0; m_alpha = 0; m_done = 0;
      for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    end else begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {active ? blend(game_px, over_px, m_alpha) : 24'h0, hsync, vsync, active};
      if (go && (m_state == 0 || m_state == 3)) m_state = 1;
      else if (!go && rs && (m_state == 1 || m_state == 2)) m_state = 3;
      m_done = 0;
      if (nf && m_state == 1) begin
        m_alpha = (m_alpha + STEP >= 256) ? 256 : m_alpha + STEP;
        if (m_alpha == 256) begin m_state = 2; m_done = 1; end
      end else if (nf && m_state == 3) begin
        m_alpha = (m_alpha - STEP <= 0) ? 0 : m_alpha - STEP;
        if (m_alpha == 0) begin m_state = 0; m_done = 1; end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_video", {5'b0, pixel_out, hsync_out, vsync_out, active_out}, {5'b0, m_pipe[2]});
    chk("model_state", {30'b0, state_out}, m_state);
    chk("model_done", {31'b0, done_out}, m_done);
  endtask

  initial begin
    int frame_left;

    tbl[0]  = mk(0, 0, 0, 1, 24'h123456, 24'hFFFFFF, 24'h123456, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 24'h123456, 24'hFFFFFF, 24'h000000, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 24'h000000, 24'hFFFFFF, 24'h000000, 1, 0);
    tbl[3]  = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'h3F3F3F, 1, 0);
    tbl[4]  = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'h7F7F7F, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'hBFBFBF, 1, 0);
    tbl[6]  = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 2, 1);
    tbl[7]  = mk(1, 0, 0, 1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 2, 0);
    tbl[8]  = mk(0, 1, 1, 1, 24'h000000, 24'hFFFFFF, 24'hBFBFBF, 3, 0);
    tbl[9]  = mk(1, 1, 0, 1, 24'h000000, 24'hFFFFFF, 24'hBFBFBF, 1, 0);
    tbl[10] = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 2, 1);
    tbl[11] = mk(0, 1, 0, 1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 3, 0);
    tbl[12] = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'hBFBFBF, 3, 0);
    tbl[13] = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'h7F7F7F, 3, 0);
    tbl[14] = mk(1, 0, 0, 1, 24'h000000, 24'hFFFFFF, 24'h7F7F7F, 1, 0);
    tbl[15] = mk(0, 1, 0, 1, 24'h000000, 24'hFFFFFF, 24'h7F7F7F, 3, 0);
    tbl[16] = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'h3F3F3F, 3, 0);
    tbl[17] = mk(0, 0, 1, 1, 24'h000000, 24'hFFFFFF, 24'h000000, 0, 1);
    tbl[18] = mk(0, 1, 0, 1, 24'h000000, 24'hFFFFFF, 24'h000000, 0, 0);

    rst = 1; hsync = 0; vsync = 0; active = 0; nf = 0; go = 0; rs = 0;
    game_px = 24'h0; over_px = 24'h0;
    tick();
    tick();
    chk("reset_outputs", {5'b0, pixel_out, hsync_out, vsync_out, active_out}, 32'h0);
    chk("reset_state", {29'b0, state_out, done_out}, 32'h0);
    rst = 0;

    foreach (tbl[i]) begin
      go = tbl[i].go; rs = tbl[i].rs; nf = tbl[i].nf; active = tbl[i].act;
      game_px = tbl[i].game; over_px = tbl[i].over;
      hsync = 1'($urandom); vsync = 1'($urandom);
      tick();
      chk($sformatf("tbl%0d_state", i), {30'b0, state_out}, tbl[i].exp_state);
      chk($sformatf("tbl%0d_done", i), {31'b0, done_out}, {31'b0, tbl[i].exp_done});
      go = 0; rs = 0; nf = 0;
      tick(); tick(); tick();
      chk($sformatf("tbl%0d_pixel", i), {8'b0, pixel_out}, {8'b0, tbl[i].exp_pix});
    end

    // Reset in the middle of a fade, then watch the first pixel emerge three cycles later
    go = 1; nf = 1; game_px = 24'h0; over_px = 24'hFFFFFF; active = 1;
    tick();
    go = 0; nf = 0;
    tick(); tick();
    rst = 1; game_px = 24'hABCDEF; hsync = 1; vsync = 1;
    tick();
    chk("midfade_rst_state", {30'b0, state_out}, 32'h0);
    chk("midfade_rst_out", {5'b0, pixel_out, hsync_out, vsync_out, active_out}, 32'h0);
    rst = 0;
    tick();
    chk("rst_lat1", {5'b0, pixel_out, hsync_out, vsync_out, active_out}, 32'h0);
    tick();
    chk("rst_lat2", {5'b0, pixel_out, hsync_out, vsync_out, active_out}, 32'h0);
    tick();
    chk("rst_lat3", {5'b0, pixel_out, hsync_out, vsync_out, active_out}, {5'b0, 24'hABCDEF, 3'b111});

    frame_left = 8;
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 599) == 0);
      go      = ($urandom_range(0, 29) == 0);
      rs      = ($urandom_range(0, 29) == 0);
      nf      = (frame_left == 0);
      frame_left = (frame_left == 0) ? $urandom_range(3, 12) : frame_left - 1;
      active  = ($urandom_range(0, 3) != 0);
      hsync   = 1'($urandom);
      vsync   = 1'($urandom);
      game_px = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      over_px = ($urandom_range(0, 7) == 0) ? 24'h000000 : 24'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
